// File: rtl/edgebank_pkg.sv
// rtl/edgebank_pkg.sv - edgebank mode encodings, defaults and edge-qualify helper
// Shared by edgebank and edgebank_chan; optional input synchroniser is EDGEBANK_SYNC_EN.
package edgebank_pkg;

  localparam logic [1:0] EDGE_OFF  = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  localparam int DEF_CHANNELS     = 4;
  localparam int DEF_PULSE_CYCLES = 1;

  // mode bit 0 qualifies rising edges, bit 1 falling edges
  function automatic logic edge_qualify(input logic [1:0] mode, input logic s, input logic prev);
    logic rise;
    logic fall;
    rise = s & ~prev;
    fall = ~s & prev;
    return (mode[0] & rise) | (mode[1] & fall);
  endfunction

endpackage

// File: rtl/edgebank_chan.sv
// rtl/edgebank_chan.sv - one edgebank channel: optional sync, prev/primed, pulse counter, pending
// With EDGEBANK_SYNC_EN defined, sig_i passes through a two-flop synchroniser first.
module edgebank_chan
  import edgebank_pkg::*;
#(
  parameter int PULSE_CYCLES = DEF_PULSE_CYCLES
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sig_i,
  input  logic       en_i,
  input  logic [1:0] mode_i,
  input  logic       ack_i,
  output logic       pulse_o,
  output logic       pending_o
);

  localparam int CW = $clog2(PULSE_CYCLES + 1);

  logic          s;
  logic          prev_q;
  logic          primed_q, primed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pending_q, pending_d;
  logic          hit;

`ifdef EDGEBANK_SYNC_EN
  logic [1:0] sync_q;
  logic [1:0] warm_q;

  assign s = sync_q[1];

  // warm_q counts synchroniser loads so reset-release transitions are never detected
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= 2'b00;
      warm_q <= 2'd0;
    end else begin
      sync_q <= {sync_q[0], sig_i};
      if (warm_q != 2'd2) warm_q <= warm_q + 2'd1;
    end
  end

  assign primed_d = primed_q | (warm_q == 2'd2);
`else
  assign s        = sig_i;
  assign primed_d = 1'b1;
`endif

  assign hit = primed_q & en_i & edge_qualify(mode_i, s, prev_q);

  always_comb begin
    cnt_d = cnt_q;
    if (hit)                cnt_d = CW'(PULSE_CYCLES);
    else if (cnt_q != '0)   cnt_d = cnt_q - CW'(1);
  end

  // a fresh hit wins over a simultaneous acknowledge
  always_comb begin
    pending_d = pending_q;
    if (hit)        pending_d = 1'b1;
    else if (ack_i) pending_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q    <= 1'b0;
      primed_q  <= 1'b0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      prev_q    <= s;
      primed_q  <= primed_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  assign pulse_o   = (cnt_q != '0);
  assign pending_o = pending_q;

endmodule

// File: rtl/edgebank.sv
// rtl/edgebank.sv - multi-channel synchronous edge detector with stretched pulse and sticky pending
// Optional per-input two-flop synchroniser enabled by defining EDGEBANK_SYNC_EN.
module edgebank
  import edgebank_pkg::*;
#(
  parameter int CHANNELS     = DEF_CHANNELS,
  parameter int PULSE_CYCLES = DEF_PULSE_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CHANNELS-1:0]   sig,
  input  logic [CHANNELS-1:0]   en,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]   ack,
  output logic [CHANNELS-1:0]   pulse,
  output logic [CHANNELS-1:0]   pending
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    edgebank_chan #(
      .PULSE_CYCLES(PULSE_CYCLES)
    ) u_chan (
      .clk_i    (clk),
      .rst_i    (rst),
      .sig_i    (sig[i]),
      .en_i     (en[i]),
      .mode_i   (mode[2*i+1:2*i]),
      .ack_i    (ack[i]),
      .pulse_o  (pulse[i]),
      .pending_o(pending[i])
    );
  end

endmodule

// File: tb/tb_edgebank.sv
// tb/tb_edgebank.sv - directed scoreboard bench for edgebank, CHANNELS=4, PULSE_CYCLES=3
// Expectations assume the default build (EDGEBANK_SYNC_EN undefined).
module tb_edgebank;
  import edgebank_pkg::*;

  localparam int CH = 4;
  localparam int PC = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] sig, en, ack;
  logic [2*CH-1:0] mode;
  logic [CH-1:0] pulse, pending;

  always #5 clk = ~clk;

  edgebank #(.CHANNELS(CH), .PULSE_CYCLES(PC)) dut (
    .clk    (clk),
    .rst    (rst),
    .sig    (sig),
    .en     (en),
    .mode   (mode),
    .ack    (ack),
    .pulse  (pulse),
    .pending(pending)
  );

  typedef struct {
    logic [CH-1:0] p;
    logic [CH-1:0] q;
    int            id;
  } exp_t;

  exp_t sb[$];
  int   checks  = 0;
  int   errors  = 0;
  int   step_no = 0;

  logic [7:0] m_rise, m_mix, m_mix_b;

  task automatic step(input logic r, input logic [CH-1:0] s, input logic [CH-1:0] e,
                      input logic [2*CH-1:0] m, input logic [CH-1:0] a,
                      input logic [CH-1:0] ep, input logic [CH-1:0] eq);
    exp_t x;
    exp_t y;
    @(negedge clk);
    rst  = r;
    sig  = s;
    en   = e;
    mode = m;
    ack  = a;
    x.p  = ep;
    x.q  = eq;
    x.id = step_no;
    step_no++;
    sb.push_back(x);
    @(posedge clk);
    #1;
    y = sb.pop_front();
    checks++;
    assert (pulse === y.p)
    else begin
      errors++;
      $error("FAIL pulse step %0d: observed %b expected %b", y.id, pulse, y.p);
    end
    checks++;
    assert (pending === y.q)
    else begin
      errors++;
      $error("FAIL pending step %0d: observed %b expected %b", y.id, pending, y.q);
    end
  endtask

  initial begin
    rst  = 1'b1;
    sig  = '0;
    en   = '0;
    mode = '0;
    ack  = '0;
    m_rise  = {EDGE_RISE, EDGE_RISE, EDGE_RISE, EDGE_RISE};
    m_mix   = {EDGE_RISE, EDGE_BOTH, EDGE_FALL, EDGE_RISE};
    m_mix_b = {EDGE_RISE, EDGE_BOTH, EDGE_FALL, EDGE_BOTH};

    // reset release with inputs held high: priming must swallow it
    step(1, 4'b1111, 4'b1111, m_rise, 4'b0000, 4'b0000, 4'b0000);
    for (int i = 0; i < 10; i++)
      step(0, 4'b1111, 4'b1111, m_rise, 4'b0000, 4'b0000, 4'b0000);

    // lower all inputs with detection disabled
    step(0, 4'b0000, 4'b0000, m_mix, 4'b0000, 4'b0000, 4'b0000);

    // ch0 rising edge: 3-cycle pulse, pending until ack
    step(0, 4'b0001, 4'b1111, m_mix, 4'b0000, 4'b0001, 4'b0001);
    step(0, 4'b0001, 4'b1111, m_mix, 4'b0000, 4'b0001, 4'b0001);
    step(0, 4'b0001, 4'b1111, m_mix, 4'b0000, 4'b0001, 4'b0001);
    step(0, 4'b0001, 4'b1111, m_mix, 4'b0000, 4'b0000, 4'b0001);
    step(0, 4'b0001, 4'b1111, m_mix, 4'b0001, 4'b0000, 4'b0000);
    step(0, 4'b0001, 4'b1111, m_mix, 4'b0000, 4'b0000, 4'b0000);

    // ch1 FALL / ch2 BOTH: raise quietly, then 1->0 and 0->1
    step(0, 4'b0111, 4'b1001, m_mix, 4'b0000, 4'b0000, 4'b0000);
    step(0, 4'b0001, 4'b1111, m_mix, 4'b0000, 4'b0110, 4'b0110);
    step(0, 4'b0001, 4'b1111, m_mix, 4'b0000, 4'b0110, 4'b0110);
    step(0, 4'b0001, 4'b1111, m_mix, 4'b0000, 4'b0110, 4'b0110);
    step(0, 4'b0001, 4'b1111, m_mix, 4'b0000, 4'b0000, 4'b0110);
    step(0, 4'b0111, 4'b1111, m_mix, 4'b0000, 4'b0100, 4'b0110);
    step(0, 4'b0111, 4'b1111, m_mix, 4'b0000, 4'b0100, 4'b0110);
    step(0, 4'b0111, 4'b1111, m_mix, 4'b0000, 4'b0100, 4'b0110);
    step(0, 4'b0111, 4'b1111, m_mix, 4'b0000, 4'b0000, 4'b0110);
    step(0, 4'b0111, 4'b1111, m_mix, 4'b0110, 4'b0000, 4'b0000);

    // ch0 BOTH toggling: continuous pulse, ends 3 cycles after last hit
    step(0, 4'b0110, 4'b1111, m_mix_b, 4'b0000, 4'b0001, 4'b0001);
    step(0, 4'b0111, 4'b1111, m_mix_b, 4'b0000, 4'b0001, 4'b0001);
    step(0, 4'b0110, 4'b1111, m_mix_b, 4'b0000, 4'b0001, 4'b0001);
    step(0, 4'b0111, 4'b1111, m_mix_b, 4'b0000, 4'b0001, 4'b0001);
    step(0, 4'b0111, 4'b1111, m_mix_b, 4'b0000, 4'b0001, 4'b0001);
    step(0, 4'b0111, 4'b1111, m_mix_b, 4'b0000, 4'b0001, 4'b0001);
    step(0, 4'b0111, 4'b1111, m_mix_b, 4'b0000, 4'b0000, 4'b0001);

    // ack coincident with hit keeps pending; ack alone clears it
    step(0, 4'b0110, 4'b1111, m_mix_b, 4'b0001, 4'b0001, 4'b0001);
    step(0, 4'b0110, 4'b1111, m_mix_b, 4'b0001, 4'b0001, 4'b0000);
    step(0, 4'b0110, 4'b1111, m_mix_b, 4'b0000, 4'b0001, 4'b0000);
    step(0, 4'b0110, 4'b1111, m_mix_b, 4'b0000, 4'b0000, 4'b0000);

    // ch3 disabled: its rising edge is ignored
    step(0, 4'b1110, 4'b0111, m_mix_b, 4'b0000, 4'b0000, 4'b0000);
    step(0, 4'b1110, 4'b0111, m_mix_b, 4'b0000, 4'b0000, 4'b0000);
    step(0, 4'b1110, 4'b1111, m_mix_b, 4'b0000, 4'b0000, 4'b0000);

    // reset mid-pulse, then priming cycle, then detection resumes
    step(0, 4'b1111, 4'b1111, m_mix_b, 4'b0000, 4'b0001, 4'b0001);
    step(1, 4'b1111, 4'b1111, m_mix_b, 4'b0000, 4'b0000, 4'b0000);
    step(0, 4'b1111, 4'b1111, m_mix_b, 4'b0000, 4'b0000, 4'b0000);
    step(0, 4'b1110, 4'b1111, m_mix_b, 4'b0000, 4'b0001, 4'b0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
